// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and constants for the two-master memory bus arbiter
package mem_bus_arbiter_pkg;

  // Arbiter FSM states: bus idle, owned by master 0, owned by master 1.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  // Master index constants, also the encoding of the round-robin "last owner".
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Address map bases for decoders and benches.
  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - bus bundle between the two masters, the arbiter and CPU_RAM
// Purpose: groups the per-master request/strobe/return signals and the shared
//   CPU_RAM bus (Addr/WriteData/MemRd/MemWr/ReadData).
// Modports:
//   master : bus-master view (drives req/rd/wr/addr/wdata, sees gnt/rdata/rvalid)
//   slave  : arbiter view (receives master requests, drives grants/returns and the RAM bus)
//   ram    : CPU_RAM view (receives Addr/WriteData/MemRd/MemWr, drives ReadData)
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              m0_req;
  logic              m0_rd;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_rvalid;

  logic              m1_req;
  logic              m1_rd;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_rvalid;

  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WriteData;
  logic              MemRd;
  logic              MemWr;
  logic [DATA_W-1:0] ReadData;

  modport master (
    output m0_req, m0_rd, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_rd, m1_wr, m1_addr, m1_wdata,
    input  m0_gnt, m0_rdata, m0_rvalid,
    input  m1_gnt, m1_rdata, m1_rvalid
  );

  modport slave (
    input  m0_req, m0_rd, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_rd, m1_wr, m1_addr, m1_wdata,
    output m0_gnt, m0_rdata, m0_rvalid,
    output m1_gnt, m1_rdata, m1_rvalid,
    output Addr, WriteData, MemRd, MemWr,
    input  ReadData
  );

  modport ram (
    input  Addr, WriteData, MemRd, MemWr,
    output ReadData
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// rtl/mem_bus_arbiter_rr_pick2.sv - combinational two-way round-robin pick
// Purpose: chooses the next bus owner from two requests and the last owner.
// Ports:
//   req0_i   : master 0 requesting
//   req1_i   : master 1 requesting
//   last_i   : index of the master that owned the bus last
//   winner_o : index of the chosen master (M0 when nobody requests; caller ignores it then)
module mem_bus_arbiter_rr_pick2
  import mem_bus_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic winner_o
);

  always_comb begin
    winner_o = M0;
    if (req0_i && req1_i) begin
      // Tie: the master that did not own the bus last goes first.
      winner_o = (last_i == M1) ? M0 : M1;
    end else if (req1_i) begin
      winner_o = M1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing the CPU_RAM bus between two masters
// Purpose: M0 (CPU data port) and M1 (boot-loader/DMA) share one RAM bus. Grant is
//   derived from the registered FSM state, ties are broken round-robin, and an owner is
//   forced off after MAX_HOLD consecutive cycles while the other master is waiting.
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   bus   : slave modport of mem_bus_arbiter_if (master requests/returns and RAM bus)
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.slave   bus
);

  localparam int                HOLD_W    = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              pick;

  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              rd_mux;
  logic              wr_mux;

  logic              m0_rvalid_q, m1_rvalid_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

  mem_bus_arbiter_rr_pick2 u_pick (
    .req0_i   (bus.m0_req),
    .req1_i   (bus.m1_req),
    .last_i   (rr_last_q),
    .winner_o (pick)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_last_q <= M1;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      hold_q    <= hold_d;
    end
  end

  // Next-state logic. Leaving an owner always records it as last and clears the hold count.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    hold_d    = hold_q;
    unique case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          state_d = (pick == M1) ? GNT1 : GNT0;
        end
      end
      GNT0: begin
        if (!bus.m0_req || (bus.m1_req && hold_q == HOLD_LAST)) begin
          state_d   = bus.m1_req ? GNT1 : IDLE;
          rr_last_d = M0;
          hold_d    = '0;
        end else if (bus.m1_req) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          hold_d = '0;
        end
      end
      GNT1: begin
        if (!bus.m1_req || (bus.m0_req && hold_q == HOLD_LAST)) begin
          state_d   = bus.m0_req ? GNT0 : IDLE;
          rr_last_d = M1;
          hold_d    = '0;
        end else if (bus.m0_req) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          hold_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: the owner's strobes reach the RAM bus; a write suppresses a simultaneous read.
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    rd_mux    = 1'b0;
    wr_mux    = 1'b0;
    unique case (state_q)
      GNT0: begin
        addr_mux  = bus.m0_addr;
        wdata_mux = bus.m0_wdata;
        rd_mux    = bus.m0_rd & ~bus.m0_wr;
        wr_mux    = bus.m0_wr;
      end
      GNT1: begin
        addr_mux  = bus.m1_addr;
        wdata_mux = bus.m1_wdata;
        rd_mux    = bus.m1_rd & ~bus.m1_wr;
        wr_mux    = bus.m1_wr;
      end
      default: begin
      end
    endcase
  end

  assign bus.Addr      = addr_mux;
  assign bus.WriteData = wdata_mux;
  assign bus.MemRd     = rd_mux;
  assign bus.MemWr     = wr_mux;
  assign bus.m0_gnt    = (state_q == GNT0);
  assign bus.m1_gnt    = (state_q == GNT1);

  // Read return: RAM data of the granted read cycle is returned one cycle later, even if
  // ownership has moved on by then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= (state_q == GNT0) && rd_mux;
      m1_rvalid_q <= (state_q == GNT1) && rd_mux;
      if ((state_q == GNT0) && rd_mux) m0_rdata_q <= bus.ReadData;
      if ((state_q == GNT1) && rd_mux) m1_rdata_q <= bus.ReadData;
    end
  end

  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model: combinational read data derived from the address.
  assign bus.ReadData = bus.MemRd ? (bus.Addr ^ 32'h1234_5678) : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    bus.m0_req = 1'b1; bus.m0_rd = 1'b0; bus.m0_wr = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b1; bus.m1_rd = 1'b0; bus.m1_wr = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;

    // Reset held with both masters requesting: everything quiet.
    #12;
    check("rst_m0_gnt", bus.m0_gnt, 0);
    check("rst_m1_gnt", bus.m1_gnt, 0);
    check("rst_memrd", bus.MemRd, 0);
    check("rst_memwr", bus.MemWr, 0);
    check("rst_addr", bus.Addr, 0);
    check("rst_wdata", bus.WriteData, 0);
    check("rst_rvalid", {bus.m0_rvalid, bus.m1_rvalid}, 0);
    check("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 0);

    // Release: M0 wins the first tie one cycle later, then 8/8 alternation with no idle cycle.
    reset = 1'b1;
    tick();
    for (int i = 0; i < 24; i++) begin
      check($sformatf("cont_m0_gnt_%0d", i), bus.m0_gnt, ((i / 8) % 2 == 0) ? 1 : 0);
      check($sformatf("cont_m1_gnt_%0d", i), bus.m1_gnt, ((i / 8) % 2 == 1) ? 1 : 0);
      tick();
    end
    // Now in GNT1 (start of M1's second turn); both release.
    check("cont_end_m1_gnt", bus.m1_gnt, 1);
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    tick();
    check("idle_gnts", {bus.m0_gnt, bus.m1_gnt}, 0);

    // Solo M1 read; a stray M0 write strobe while ungranted must never reach the bus.
    bus.m1_req = 1'b1; bus.m1_rd = 1'b1; bus.m1_addr = 32'h4000_0010;
    bus.m0_wr = 1'b1; bus.m0_addr = 32'h0000_0044;
    #1;
    check("idle_memwr", bus.MemWr, 0);
    check("idle_memrd", bus.MemRd, 0);
    tick();
    check("solo_m1_gnt", bus.m1_gnt, 1);
    check("solo_addr", bus.Addr, 64'h4000_0010);
    check("solo_memrd", bus.MemRd, 1);
    check("solo_memwr_stray", bus.MemWr, 0);
    tick();
    check("solo_m1_rvalid", bus.m1_rvalid, 1);
    check("solo_m1_rdata", bus.m1_rdata, 64'h5234_5668);
    check("solo_m0_rvalid", bus.m0_rvalid, 0);
    bus.m1_req = 1'b0; bus.m1_rd = 1'b0; bus.m0_wr = 1'b0;
    tick();
    check("solo_end_rvalid", bus.m1_rvalid, 0);
    check("solo_end_gnts", {bus.m0_gnt, bus.m1_gnt}, 0);

    // Release handover: M0 reads in its last granted cycle while M1 waits.
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    tick();
    check("ho_m0_gnt", bus.m0_gnt, 1);
    bus.m0_req = 1'b0; bus.m0_rd = 1'b1; bus.m0_addr = 32'h0000_0020;
    #1;
    check("ho_memrd", bus.MemRd, 1);
    check("ho_addr", bus.Addr, 64'h20);
    tick();
    check("ho_m1_gnt", bus.m1_gnt, 1);
    check("ho_m0_gnt_off", bus.m0_gnt, 0);
    check("ho_m0_rvalid", bus.m0_rvalid, 1);
    check("ho_m0_rdata", bus.m0_rdata, 64'h1234_5658);
    check("ho_m1_rvalid", bus.m1_rvalid, 0);
    bus.m0_rd = 1'b0; bus.m1_req = 1'b0;
    tick();
    check("ho_m0_rvalid_once", bus.m0_rvalid, 0);
    check("ho_idle", {bus.m0_gnt, bus.m1_gnt}, 0);

    // Read and write together: write wins, no read return.
    bus.m0_req = 1'b1;
    tick();
    bus.m0_rd = 1'b1; bus.m0_wr = 1'b1; bus.m0_wdata = 32'h7568_0150; bus.m0_addr = 32'h0;
    #1;
    check("rw_m0_gnt", bus.m0_gnt, 1);
    check("rw_memwr", bus.MemWr, 1);
    check("rw_memrd", bus.MemRd, 0);
    check("rw_wdata", bus.WriteData, 64'h7568_0150);
    check("rw_addr", bus.Addr, 0);
    tick();
    check("rw_no_rvalid", bus.m0_rvalid, 0);
    bus.m0_req = 1'b0; bus.m0_rd = 1'b0; bus.m0_wr = 1'b0;
    tick();

    // Async reset in the middle of an M1 read burst.
    bus.m1_req = 1'b1; bus.m1_rd = 1'b1; bus.m1_addr = 32'h4000_0040;
    tick();
    check("ar_m1_gnt", bus.m1_gnt, 1);
    check("ar_memrd", bus.MemRd, 1);
    tick();
    check("ar_rvalid_pre", bus.m1_rvalid, 1);
    check("ar_rdata_pre", bus.m1_rdata, 64'h5234_5638);
    #2;
    reset = 1'b0;
    #1;
    check("ar_m1_gnt_off", bus.m1_gnt, 0);
    check("ar_memrd_off", bus.MemRd, 0);
    check("ar_rvalid_off", bus.m1_rvalid, 0);
    check("ar_rdata_clr", bus.m1_rdata, 0);
    tick();
    bus.m1_req = 1'b0; bus.m1_rd = 1'b0;
    reset = 1'b1;
    tick();
    check("ar_post_rvalid", {bus.m0_rvalid, bus.m1_rvalid}, 0);
    check("ar_post_gnts", {bus.m0_gnt, bus.m1_gnt}, 0);
    tick();
    check("ar_post_rvalid2", {bus.m0_rvalid, bus.m1_rvalid}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
